// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the inverse-cipher datapath.
package aes_pkg;

  localparam int unsigned NB_BYTES = 16;
  localparam int unsigned NB_WORDS = 4;

  typedef logic [0:NB_BYTES-1][7:0] state_t;
  typedef logic [0:NB_WORDS-1][31:0] key_t;

  // Row-major inverse S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ gmul2(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ gmul2(b);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/inv_add_roundkey.sv
// AddRoundKey: key word w covers state bytes 4w..4w+3, MSB first, so a flat XOR lines up.
module inv_add_roundkey
  import aes_pkg::*;
(
  input  state_t st,
  input  key_t   key,
  output state_t y_c
);

  assign y_c = st ^ state_t'(key);

endmodule

// File: rtl/inv_mix_columns.sv
// Combinational InvMixColumns over all four columns.
module inv_mix_columns
  import aes_pkg::*;
(
  input  state_t st,
  output state_t y_c
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign y_c[4*c+r] = mule(st[4*c+r])
                        ^ mulb(st[4*c+((r+1)%4)])
                        ^ muld(st[4*c+((r+2)%4)])
                        ^ mul9(st[4*c+((r+3)%4)]);
    end
  end

endmodule

// File: rtl/inv_sub_byte.sv
// Single-byte InvSubBytes lookup.
module inv_sub_byte
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y_c
);

  assign y_c = inv_sbox(a);

endmodule

// File: rtl/inv_round_pipe.sv
// Two-stage elastic inverse AES round: InvSubBytes, then AddRoundKey and optional InvMixColumns.
module inv_round_pipe
  import aes_pkg::*;
#(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned MIX_EN    = 1,
  parameter int unsigned KEY_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  state_t           data_in,
  input  key_t             round_key,
  input  logic             is_final,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output state_t           data_out,
  output logic [TAG_W-1:0] tag_out
);

  logic             s1_valid;
  state_t           s1_sbox;
  logic             s1_final;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;

  state_t sbox_c;
  key_t   key_c;
  state_t ark_c;
  state_t nxt_c;
  logic   s2_load_c;
  logic   accept_c;

  assign s2_load_c = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load_c;
  assign accept_c  = in_valid && in_ready;
  assign out_valid = s2_valid;

  for (genvar i = 0; i < NB_BYTES; i++) begin : g_sbox
    inv_sub_byte u_sub (
      .a   (data_in[i]),
      .y_c (sbox_c[i])
    );
  end

  // Key either rides along from stage 1 or is taken live at the stage-2 load.
  if (KEY_STAGE == 1) begin : g_key_s1
    key_t s1_key;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_key <= '0;
      end else if (accept_c) begin
        s1_key <= round_key;
      end
    end
    assign key_c = s1_key;
  end else begin : g_key_s2
    assign key_c = round_key;
  end

  inv_add_roundkey u_ark (
    .st  (s1_sbox),
    .key (key_c),
    .y_c (ark_c)
  );

  if (MIX_EN != 0) begin : g_mix
    state_t mix_c;
    inv_mix_columns u_mix (
      .st  (ark_c),
      .y_c (mix_c)
    );
    assign nxt_c = s1_final ? ark_c : mix_c;
  end else begin : g_nomix
    assign nxt_c = ark_c;
  end

  // Stage 1: substituted state plus sideband; data holds when not refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sbox  <= '0;
      s1_final <= 1'b0;
      s1_tag   <= '0;
    end else if (accept_c) begin
      s1_valid <= 1'b1;
      s1_sbox  <= sbox_c;
      s1_final <= is_final;
      s1_tag   <= tag_in;
    end else if (s2_load_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 doubles as the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      data_out <= '0;
      tag_out  <= '0;
    end else if (s2_load_c) begin
      s2_valid <= 1'b1;
      data_out <= nxt_c;
      tag_out  <= s1_tag;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule
